// File: rtl/player_pkg.sv
// -----------------------------------------------------------------------------
// player_pkg
// Shared definitions for the player movement engine: default widths, the
// empty-cell code returned by the map, the update FSM state encoding and the
// quarter-turn helper used for strafe direction lookups.
// -----------------------------------------------------------------------------
package player_pkg;

  localparam int X_W_DEF         = 14;
  localparam int Y_W_DEF         = 13;
  localparam int ANG_W_DEF       = 8;
  localparam int CELL_SHIFT_DEF  = 8;
  localparam int TURN_STEP_DEF   = 2;
  localparam int SPEED_SHIFT_DEF = 0;
  localparam int TICK_CYCLES_DEF = 1000000;

  localparam logic [2:0] CELL_EMPTY = 3'd0;

  localparam int QUARTER_TURN = 2 ** (ANG_W_DEF - 2);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_EVAL    = 4'd1,
    S_FWD_VEC = 4'd2,
    S_STR_VEC = 4'd3,
    S_ADDR_X  = 4'd4,
    S_READ_X  = 4'd5,
    S_ADDR_Y  = 4'd6,
    S_READ_Y  = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  // Quarter of a full turn for an angle field of the given width.
  function automatic int quarter_turn(input int ang_w);
    return 1 << (ang_w - 2);
  endfunction

endpackage

// File: rtl/player_motion_ctrl_cell_probe.sv
// -----------------------------------------------------------------------------
// cell_probe
// One map probe, reused for the x and then the y axis. On load it registers
// the cell address (held stable until the next load) together with the
// candidate's overflow flag. The map answers one cycle after the address, so
// accept is meaningful in the cycle following the address cycle.
//
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   load           capture cell_x/cell_y/ovf this cycle
//   cell_x, cell_y cell address to probe
//   ovf            candidate position fell outside the map range
//   grid_out       cell type from the map memory
//   grid_x, grid_y registered cell address towards the map memory
//   accept         cell is empty and the candidate did not overflow
// -----------------------------------------------------------------------------
module cell_probe
  import player_pkg::*;
#(
  parameter int GX_W = 6,
  parameter int GY_W = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic [GX_W-1:0] cell_x,
  input  logic [GY_W-1:0] cell_y,
  input  logic            ovf,
  input  logic [2:0]      grid_out,
  output logic [GX_W-1:0] grid_x,
  output logic [GY_W-1:0] grid_y,
  output logic            accept
);

  logic ovf_held;

  always_ff @(posedge clock) begin
    if (reset) begin
      grid_x   <= '0;
      grid_y   <= '0;
      ovf_held <= 1'b0;
    end else if (load) begin
      grid_x   <= cell_x;
      grid_y   <= cell_y;
      ovf_held <= ovf;
    end
  end

  // An overflowed candidate is never accepted, whatever the aliased cell holds.
  assign accept = !ovf_held && (grid_out == CELL_EMPTY);

endmodule

// File: rtl/player_motion_ctrl.sv
// -----------------------------------------------------------------------------
// player_motion_ctrl
// Once-per-frame player pose update: turn, forward/back move and strafe are
// combined into one delta (doubled while running), then each axis is checked
// against the map independently so the player slides along walls. Updates are
// rate limited by a free-running tick counter.
//
// Ports:
//   clock, reset              system clock, synchronous active-high reset
//   start / done              request one update / one-cycle completion pulse
//   key_*                     key levels, latched when the update is evaluated
//   cur_pos_x/y, cur_angle    current pose
//   next_pos_x/y, next_angle  updated pose, valid from done until next done
//   blocked_x/y               axis motion rejected in the last update
//   vec_angle -> vec_x/vec_y  shared direction lookup (combinational outside)
//   grid_x/y -> grid_out      map cell probe (one-cycle read latency outside)
// -----------------------------------------------------------------------------
module player_motion_ctrl
  import player_pkg::*;
#(
  parameter int X_W         = X_W_DEF,
  parameter int Y_W         = Y_W_DEF,
  parameter int ANG_W       = ANG_W_DEF,
  parameter int CELL_SHIFT  = CELL_SHIFT_DEF,
  parameter int TURN_STEP   = TURN_STEP_DEF,
  parameter int SPEED_SHIFT = SPEED_SHIFT_DEF,
  parameter int TICK_CYCLES = TICK_CYCLES_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    done,
  input  logic                    key_right,
  input  logic                    key_left,
  input  logic                    key_fwd,
  input  logic                    key_back,
  input  logic                    key_str_l,
  input  logic                    key_str_r,
  input  logic                    key_run,
  input  logic [X_W-1:0]          cur_pos_x,
  input  logic [Y_W-1:0]          cur_pos_y,
  input  logic [ANG_W-1:0]        cur_angle,
  output logic [X_W-1:0]          next_pos_x,
  output logic [Y_W-1:0]          next_pos_y,
  output logic [ANG_W-1:0]        next_angle,
  output logic                    blocked_x,
  output logic                    blocked_y,
  output logic [ANG_W-1:0]        vec_angle,
  input  logic signed [X_W:0]     vec_x,
  input  logic signed [Y_W:0]     vec_y,
  output logic [X_W-CELL_SHIFT-1:0] grid_x,
  output logic [Y_W-CELL_SHIFT-1:0] grid_y,
  input  logic [2:0]              grid_out
);

  localparam int GX_W  = X_W - CELL_SHIFT;
  localparam int GY_W  = Y_W - CELL_SHIFT;
  // Three extra bits: sign, forward+strafe sum, run doubling.
  localparam int DX_W  = X_W + 3;
  localparam int DY_W  = Y_W + 3;
  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TICK_LOAD = CNT_W'(TICK_CYCLES - 1);
  localparam logic [ANG_W-1:0] TURN_AMT  = ANG_W'(TURN_STEP);
  localparam logic [ANG_W-1:0] QTR       = ANG_W'(quarter_turn(ANG_W));

  state_t state, state_nxt;
  logic [CNT_W-1:0] tick_cnt;

  // Keys and pose captured at evaluation time.
  logic k_fwd, k_back, k_str_l, k_str_r, k_run;
  logic [X_W-1:0]   pos_x;
  logic [Y_W-1:0]   pos_y;
  logic [ANG_W-1:0] ang;

  logic signed [DX_W-1:0] fwd_x;
  logic signed [DY_W-1:0] fwd_y;
  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;
  logic move_x, move_y, ovf_y, x_ok;

  logic [ANG_W-1:0]       eval_ang, str_ang;
  logic signed [DX_W-1:0] vx_full, fwd_term_x, str_term_x, dsum_x, dx, cand_x_new;
  logic signed [DY_W-1:0] vy_full, fwd_term_y, str_term_y, dsum_y, dy, cand_y_new;
  logic ovf_x_new, ovf_y_new;
  logic [X_W-1:0] x_final;
  logic probe_load, probe_ovf, probe_accept;
  logic [GX_W-1:0] probe_cx;
  logic [GY_W-1:0] probe_cy;

  // Turned heading; right and left together cancel.
  always_comb begin
    eval_ang = cur_angle;
    if (key_right && !key_left) begin
      eval_ang = cur_angle + TURN_AMT;
    end else if (key_left && !key_right) begin
      eval_ang = cur_angle - TURN_AMT;
    end else begin
      eval_ang = cur_angle;
    end
  end

  assign str_ang = k_str_r ? (ang + QTR) : (ang - QTR);

  assign vx_full = $signed({{2{vec_x[X_W]}}, vec_x}) >>> SPEED_SHIFT;
  assign vy_full = $signed({{2{vec_y[Y_W]}}, vec_y}) >>> SPEED_SHIFT;

  // Forward term (FWD_VEC) and strafe term plus candidate positions (STR_VEC).
  always_comb begin
    fwd_term_x = '0;
    fwd_term_y = '0;
    if (k_fwd && !k_back) begin
      fwd_term_x = vx_full;
      fwd_term_y = vy_full;
    end else if (k_back && !k_fwd) begin
      fwd_term_x = -vx_full;
      fwd_term_y = -vy_full;
    end else begin
      fwd_term_x = '0;
      fwd_term_y = '0;
    end
    // The strafe direction is already encoded in the lookup angle.
    str_term_x = (k_str_l ^ k_str_r) ? vx_full : '0;
    str_term_y = (k_str_l ^ k_str_r) ? vy_full : '0;
    dsum_x     = fwd_x + str_term_x;
    dsum_y     = fwd_y + str_term_y;
    dx         = k_run ? (dsum_x <<< 1) : dsum_x;
    dy         = k_run ? (dsum_y <<< 1) : dsum_y;
    cand_x_new = $signed({3'b000, pos_x}) + dx;
    cand_y_new = $signed({3'b000, pos_y}) + dy;
    // Any bit above the position width means below zero or past the top.
    ovf_x_new  = (cand_x_new[DX_W-1:X_W] != 3'b000);
    ovf_y_new  = (cand_y_new[DY_W-1:Y_W] != 3'b000);
  end

  // The y probe runs from wherever x ended up.
  assign x_final = (move_x && probe_accept) ? cand_x : pos_x;

  // Probe address source: x probe loads leaving STR_VEC, y probe leaving READ_X.
  always_comb begin
    probe_load = 1'b0;
    probe_cx   = '0;
    probe_cy   = '0;
    probe_ovf  = 1'b0;
    if (state == S_STR_VEC) begin
      probe_load = 1'b1;
      probe_cx   = cand_x_new[X_W-1:CELL_SHIFT];
      probe_cy   = pos_y[Y_W-1:CELL_SHIFT];
      probe_ovf  = ovf_x_new;
    end else if (state == S_READ_X) begin
      probe_load = 1'b1;
      probe_cx   = x_final[X_W-1:CELL_SHIFT];
      probe_cy   = cand_y[Y_W-1:CELL_SHIFT];
      probe_ovf  = ovf_y;
    end else begin
      probe_load = 1'b0;
    end
  end

  cell_probe #(
    .GX_W(GX_W),
    .GY_W(GY_W)
  ) u_probe (
    .clock   (clock),
    .reset   (reset),
    .load    (probe_load),
    .cell_x  (probe_cx),
    .cell_y  (probe_cy),
    .ovf     (probe_ovf),
    .grid_out(grid_out),
    .grid_x  (grid_x),
    .grid_y  (grid_y),
    .accept  (probe_accept)
  );

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    state_nxt = start ? S_EVAL : S_IDLE;
      S_EVAL:    state_nxt = (tick_cnt != '0) ? S_DONE : S_FWD_VEC;
      S_FWD_VEC: state_nxt = S_STR_VEC;
      S_STR_VEC: state_nxt = S_ADDR_X;
      S_ADDR_X:  state_nxt = S_READ_X;
      S_READ_X:  state_nxt = S_ADDR_Y;
      S_ADDR_Y:  state_nxt = S_READ_Y;
      S_READ_Y:  state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State register and done pulse (high exactly while in DONE).
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == S_DONE);
    end
  end

  // Rate limiter: reloaded by an accepted evaluation, otherwise counts down.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if ((state == S_EVAL) && (tick_cnt == '0)) begin
      tick_cnt <= TICK_LOAD;
    end else if (tick_cnt != '0) begin
      tick_cnt <= tick_cnt - 1'b1;
    end
  end

  // Update datapath; results only move into next_*/blocked_* on entry to DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      k_fwd      <= 1'b0;
      k_back     <= 1'b0;
      k_str_l    <= 1'b0;
      k_str_r    <= 1'b0;
      k_run      <= 1'b0;
      pos_x      <= '0;
      pos_y      <= '0;
      ang        <= '0;
      fwd_x      <= '0;
      fwd_y      <= '0;
      cand_x     <= '0;
      cand_y     <= '0;
      move_x     <= 1'b0;
      move_y     <= 1'b0;
      ovf_y      <= 1'b0;
      x_ok       <= 1'b0;
      vec_angle  <= '0;
      next_pos_x <= '0;
      next_pos_y <= '0;
      next_angle <= '0;
      blocked_x  <= 1'b0;
      blocked_y  <= 1'b0;
    end else begin
      case (state)
        S_EVAL: begin
          k_fwd   <= key_fwd;
          k_back  <= key_back;
          k_str_l <= key_str_l;
          k_str_r <= key_str_r;
          k_run   <= key_run;
          pos_x   <= cur_pos_x;
          pos_y   <= cur_pos_y;
          if (tick_cnt != '0) begin
            next_pos_x <= cur_pos_x;
            next_pos_y <= cur_pos_y;
            next_angle <= cur_angle;
            blocked_x  <= 1'b0;
            blocked_y  <= 1'b0;
          end else begin
            ang       <= eval_ang;
            vec_angle <= eval_ang;
          end
        end
        S_FWD_VEC: begin
          fwd_x     <= fwd_term_x;
          fwd_y     <= fwd_term_y;
          vec_angle <= str_ang;
        end
        S_STR_VEC: begin
          cand_x <= cand_x_new[X_W-1:0];
          cand_y <= cand_y_new[Y_W-1:0];
          move_x <= (dx != '0);
          move_y <= (dy != '0);
          ovf_y  <= ovf_y_new;
        end
        S_READ_X: begin
          x_ok <= move_x && probe_accept;
        end
        S_READ_Y: begin
          next_pos_x <= x_ok ? cand_x : pos_x;
          next_pos_y <= (move_y && probe_accept) ? cand_y : pos_y;
          next_angle <= ang;
          blocked_x  <= move_x && !x_ok;
          blocked_y  <= move_y && !probe_accept;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_motion_ctrl.sv
module tb_player_motion_ctrl;

  localparam int X_W         = 14;
  localparam int Y_W         = 13;
  localparam int ANG_W       = 8;
  localparam int CELL_SHIFT  = 8;
  localparam int TURN_STEP   = 2;
  localparam int SPEED_SHIFT = 0;
  localparam int TICK_CYCLES = 40;
  localparam int NANG        = 1 << ANG_W;

  logic clock = 1'b0;
  logic reset, start, done;
  logic key_right, key_left, key_fwd, key_back, key_str_l, key_str_r, key_run;
  logic [X_W-1:0]   cur_pos_x, next_pos_x;
  logic [Y_W-1:0]   cur_pos_y, next_pos_y;
  logic [ANG_W-1:0] cur_angle, next_angle, vec_angle;
  logic blocked_x, blocked_y;
  logic signed [X_W:0] vec_x;
  logic signed [Y_W:0] vec_y;
  logic [X_W-CELL_SHIFT-1:0] grid_x;
  logic [Y_W-CELL_SHIFT-1:0] grid_y;
  logic [2:0] grid_out;

  logic signed [X_W:0] lut_x [NANG];
  logic signed [Y_W:0] lut_y [NANG];
  logic [2:0] cell_map [32][64];

  int n_checks = 0;
  int n_fail   = 0;
  bit have_acc;
  longint t_acc;
  int exp_nx, exp_ny, exp_na;
  bit exp_bx, exp_by;

  player_motion_ctrl #(
    .X_W(X_W), .Y_W(Y_W), .ANG_W(ANG_W), .CELL_SHIFT(CELL_SHIFT),
    .TURN_STEP(TURN_STEP), .SPEED_SHIFT(SPEED_SHIFT), .TICK_CYCLES(TICK_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .done(done),
    .key_right(key_right), .key_left(key_left), .key_fwd(key_fwd),
    .key_back(key_back), .key_str_l(key_str_l), .key_str_r(key_str_r),
    .key_run(key_run),
    .cur_pos_x(cur_pos_x), .cur_pos_y(cur_pos_y), .cur_angle(cur_angle),
    .next_pos_x(next_pos_x), .next_pos_y(next_pos_y), .next_angle(next_angle),
    .blocked_x(blocked_x), .blocked_y(blocked_y),
    .vec_angle(vec_angle), .vec_x(vec_x), .vec_y(vec_y),
    .grid_x(grid_x), .grid_y(grid_y), .grid_out(grid_out)
  );

  always #5 clock = ~clock;

  assign vec_x = lut_x[vec_angle];
  assign vec_y = lut_y[vec_angle];

  always @(posedge clock) grid_out <= cell_map[grid_y][grid_x];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: the pose rules applied with plain integer arithmetic.
  function automatic void predict(input bit accepted);
    int ang, sa, fx, fy, sx, sy, dx, dy, cx, cy, xf;
    bit okx, oky;
    if (!accepted) begin
      exp_nx = cur_pos_x; exp_ny = cur_pos_y; exp_na = cur_angle;
      exp_bx = 1'b0;      exp_by = 1'b0;
      return;
    end
    ang = (int'(cur_angle) + TURN_STEP * (int'(key_right) - int'(key_left))) & (NANG - 1);
    fx = 0; fy = 0; sx = 0; sy = 0;
    if (key_fwd != key_back) begin
      fx = int'(lut_x[ang]) >>> SPEED_SHIFT;
      fy = int'(lut_y[ang]) >>> SPEED_SHIFT;
      if (key_back) begin fx = -fx; fy = -fy; end
    end
    if (key_str_l != key_str_r) begin
      sa = (key_str_r ? ang + NANG / 4 : ang - NANG / 4) & (NANG - 1);
      sx = int'(lut_x[sa]) >>> SPEED_SHIFT;
      sy = int'(lut_y[sa]) >>> SPEED_SHIFT;
    end
    dx = (fx + sx) * (key_run ? 2 : 1);
    dy = (fy + sy) * (key_run ? 2 : 1);
    cx = int'(cur_pos_x) + dx;
    cy = int'(cur_pos_y) + dy;
    okx = 1'b0;
    if (dx != 0 && cx >= 0 && cx < (1 << X_W))
      okx = (cell_map[int'(cur_pos_y) >> CELL_SHIFT][cx >> CELL_SHIFT] == 3'd0);
    xf = okx ? cx : int'(cur_pos_x);
    oky = 1'b0;
    if (dy != 0 && cy >= 0 && cy < (1 << Y_W))
      oky = (cell_map[cy >> CELL_SHIFT][xf >> CELL_SHIFT] == 3'd0);
    exp_nx = xf;
    exp_ny = oky ? cy : int'(cur_pos_y);
    exp_na = ang;
    exp_bx = (dx != 0) && !okx;
    exp_by = (dy != 0) && !oky;
  endfunction

  task automatic set_keys(input logic [6:0] k);
    {key_right, key_left, key_fwd, key_back, key_str_l, key_str_r, key_run} = k;
  endtask

  task automatic set_pose(input int x, input int y, input int a);
    cur_pos_x = X_W'(x); cur_pos_y = Y_W'(y); cur_angle = ANG_W'(a);
  endtask

  task automatic tick_wait(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clock); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0;
    tick_wait(2);
    reset = 1'b0;
    have_acc = 1'b0;
    exp_nx = 0; exp_ny = 0; exp_na = 0; exp_bx = 1'b0; exp_by = 1'b0;
  endtask

  // One start request; start is held for 'hold' extra edges to show it is dropped.
  task automatic run_update(input int hold, input string tag);
    bit accepted, found;
    int k;
    logic [31:0] held;
    longint t_eval;
    held = {5'd0, next_pos_x, next_pos_y};
    start = 1'b1;
    @(posedge clock); #1;
    t_eval = longint'($time) - 1 + 10;
    accepted = !have_acc || (t_eval - t_acc >= TICK_CYCLES * 10);
    if (accepted) begin have_acc = 1'b1; t_acc = t_eval; end
    predict(accepted);
    k = 0; found = 1'b0;
    while (!found && k < 20) begin
      if (k >= hold) start = 1'b0;
      @(posedge clock); #1; k++;
      if (done) found = 1'b1;
      else check_eq({tag, "_hold"}, {5'd0, next_pos_x, next_pos_y}, held);
    end
    start = 1'b0;
    if (!found) begin
      check_eq({tag, "_done_timeout"}, 32'(done), 32'd1);
      return;
    end
    check_eq({tag, "_latency"}, k, accepted ? 7 : 1);
    check_eq({tag, "_nx"}, next_pos_x, exp_nx);
    check_eq({tag, "_ny"}, next_pos_y, exp_ny);
    check_eq({tag, "_na"}, next_angle, exp_na);
    check_eq({tag, "_blk"}, {blocked_x, blocked_y}, {exp_bx, exp_by});
    @(posedge clock); #1;
    check_eq({tag, "_pulse"}, done, 1'b0);
    check_eq({tag, "_keep"}, {5'd0, next_pos_x, next_pos_y}, {5'd0, X_W'(exp_nx), Y_W'(exp_ny)});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < NANG; a++) begin lut_x[a] = '0; lut_y[a] = '0; end
    for (int y = 0; y < 32; y++) for (int x = 0; x < 64; x++) cell_map[y][x] = 3'd0;
    set_keys(7'b0); set_pose(0, 0, 0);
    start = 1'b0; reset = 1'b0;
    #1;
    do_reset();
    check_eq("rst_next", {5'd0, next_pos_x, next_pos_y}, 32'd0);
    check_eq("rst_angle", next_angle, 8'd0);
    check_eq("rst_misc", {done, blocked_x, blocked_y}, 3'b000);
    check_eq("rst_vec_grid", {vec_angle, grid_x, grid_y}, 19'd0);

    // Plain forward step.
    lut_x[0] = 15'sd256; lut_y[0] = 14'sd0;
    set_keys(7'b0010000); set_pose(1000, 1000, 0);
    run_update(0, "fwd");
    check_eq("fwd_abs", {5'd0, next_pos_x, next_pos_y}, {5'd0, 14'd1256, 13'd1000});

    // Immediate retry is rate limited and echoes the current pose.
    set_pose(500, 600, 7);
    run_update(2, "supp");
    check_eq("supp_abs", {5'd0, next_pos_x, next_pos_y}, {5'd0, 14'd500, 13'd600});

    // Diagonal into a wall: x blocked, y slides; y probe must use x=1000.
    tick_wait(TICK_CYCLES);
    lut_x[0] = 15'sd256; lut_y[0] = 14'sd256;
    cell_map[3][4] = 3'd1; cell_map[4][4] = 3'd2;
    set_keys(7'b0010000); set_pose(1000, 1000, 0);
    run_update(1, "slide");
    check_eq("slide_abs", {5'd0, next_pos_x, next_pos_y}, {5'd0, 14'd1000, 13'd1256});
    check_eq("slide_blk", {blocked_x, blocked_y}, 2'b10);
    cell_map[3][4] = 3'd0; cell_map[4][4] = 3'd0;

    // Turning wraps; both turn keys cancel.
    tick_wait(TICK_CYCLES);
    set_keys(7'b0100000); set_pose(2000, 2000, 1);
    run_update(0, "turn_l");
    check_eq("turn_l_abs", next_angle, 8'd255);
    tick_wait(TICK_CYCLES);
    set_keys(7'b1100000);
    run_update(0, "turn_lr");
    check_eq("turn_lr_abs", next_angle, 8'd1);

    // Running backwards past zero underflows: x blocked, no wrap.
    tick_wait(TICK_CYCLES);
    lut_x[0] = -15'sd200; lut_y[0] = 14'sd0;
    set_keys(7'b0010001); set_pose(300, 1000, 0);
    run_update(0, "under");
    check_eq("under_abs", {next_pos_x, blocked_x}, {14'd300, 1'b1});

    // Reset in the middle of READ_X.
    tick_wait(TICK_CYCLES);
    lut_x[0] = 15'sd100; lut_y[0] = 14'sd50;
    set_keys(7'b0010000); set_pose(4000, 4000, 0);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    tick_wait(4);
    reset = 1'b1;
    tick_wait(1);
    reset = 1'b0;
    check_eq("mid_rst_done", done, 1'b0);
    check_eq("mid_rst_out", {5'd0, next_pos_x, next_pos_y}, 32'd0);
    check_eq("mid_rst_vec_grid", {vec_angle, grid_x, grid_y}, 19'd0);
    tick_wait(8);
    check_eq("mid_rst_no_done", done, 1'b0);
    have_acc = 1'b0;
    exp_nx = 0; exp_ny = 0;
    run_update(0, "after_rst");

    // Randomised updates on a random map and direction table.
    for (int a = 0; a < NANG; a++) begin
      lut_x[a] = 15'($signed($urandom_range(0, 1200)) - 600);
      lut_y[a] = 14'($signed($urandom_range(0, 1200)) - 600);
    end
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 64; x++)
        cell_map[y][x] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    for (int n = 0; n < 60; n++) begin
      tick_wait($urandom_range(0, 45));
      set_keys(7'($urandom));
      set_pose($urandom_range(0, (1 << X_W) - 1), $urandom_range(0, (1 << Y_W) - 1),
               $urandom_range(0, NANG - 1));
      run_update($urandom_range(0, 2), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
